// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter
// Read-side drain engine for an async FIFO. Pops show-ahead words from the
// FIFO read port and presents them as a registered valid/ready stream through
// a 2-entry skid buffer (head drives m_data, tail absorbs the word that was
// already in flight when the consumer stalled). The pop strobe depends only on
// registered state, rempty and flush, never on m_ready, so it closes timing
// against the FIFO without a combinational path from the downstream consumer.
module fifo_rd_stream_adapter #(
    parameter int D_WIDTH   = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 rempty,
    input  logic [D_WIDTH-1:0]   rdata,
    output logic                 rinc,
    input  logic                 flush,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [D_WIDTH-1:0]   m_data,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] word_cnt
);

    // Skid buffer fill level; the encoding doubles as the occupancy output.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t               state_reg;
    logic [D_WIDTH-1:0]   head_reg;
    logic [D_WIDTH-1:0]   tail_reg;
    logic                 valid_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic                 pop;
    logic                 take;

    // Pop whenever the FIFO has a word and a slot is free; flush and reset
    // both veto the pop so no word leaves the FIFO only to be discarded.
    assign pop  = rrst_n && !rempty && (state_reg != ST_TWO) && !flush;
    assign take = valid_reg && m_ready;

    // Buffer state machine: capture into the first free slot, shift tail to
    // head on delivery, count delivered words, flush empties the buffer.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_reg <= ST_EMPTY;
            head_reg  <= '0;
            tail_reg  <= '0;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            // A delivery in the flush cycle still happened downstream.
            if (take) begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            if (flush) begin
                state_reg <= ST_EMPTY;
                valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_EMPTY: begin
                        if (pop) begin
                            head_reg  <= rdata;
                            state_reg <= ST_ONE;
                            valid_reg <= 1'b1;
                        end
                    end
                    ST_ONE: begin
                        if (pop && !take) begin
                            tail_reg  <= rdata;
                            state_reg <= ST_TWO;
                        end else if (!pop && take) begin
                            state_reg <= ST_EMPTY;
                            valid_reg <= 1'b0;
                        end else if (pop && take) begin
                            // Streaming case: the fresh word replaces the
                            // consumed head, occupancy stays at one.
                            head_reg <= rdata;
                        end
                    end
                    ST_TWO: begin
                        if (take) begin
                            head_reg  <= tail_reg;
                            state_reg <= ST_ONE;
                        end
                    end
                    default: begin
                        state_reg <= ST_EMPTY;
                        valid_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rinc      = pop;
    assign m_valid   = valid_reg;
    assign m_data    = head_reg;
    assign occupancy = state_reg;
    assign word_cnt  = cnt_reg;

endmodule
